// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : noc_pkg
// Description : Shared constants for the 5-port mesh router: port indices,
//               flit format and output-port arbiter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package noc_pkg;

    localparam int PORT_LOCAL = 0;
    localparam int PORT_WEST  = 1;
    localparam int PORT_NORTH = 2;
    localparam int PORT_EAST  = 3;
    localparam int PORT_SOUTH = 4;

    localparam int NUM_PORTS  = 5;
    localparam int IDX_W      = 3;

    localparam int FLIT_W     = 18;
    localparam int FLIT_TYPE_HI = 17;
    localparam int FLIT_TYPE_LO = 16;

    localparam logic [1:0] FLIT_BODY   = 2'b00;
    localparam logic [1:0] FLIT_HEAD   = 2'b01;
    localparam logic [1:0] FLIT_TAIL   = 2'b10;
    localparam logic [1:0] FLIT_SINGLE = 2'b11;

    localparam logic [0:0] ARB_IDLE   = 1'b0;
    localparam logic [0:0] ARB_LOCKED = 1'b1;

    // Pointer to the port after idx, wrapping at n-1.
    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx, input int n);
        if (int'(idx) >= n - 1)
            return '0;
        return idx + IDX_W'(1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_priority_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_priority_picker
// Description : Combinational round-robin picker: first set request bit found
//               scanning upward from rr_ptr, modulo NUM_PORTS.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_picker #(
    parameter int NUM_PORTS = 5
) (
    input  logic [NUM_PORTS-1:0]        mreq,
    input  logic [noc_pkg::IDX_W-1:0]   rr_ptr,
    output logic [NUM_PORTS-1:0]        winner,
    output logic [noc_pkg::IDX_W-1:0]   winner_idx
);
    import noc_pkg::*;

    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_cand;
    logic             w_found;

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        w_found    = 1'b0;
        w_sum      = '0;
        w_cand     = '0;
        for (int off = 0; off < NUM_PORTS; off++) begin
            w_sum = {1'b0, rr_ptr} + (IDX_W+1)'(off);
            if (w_sum >= (IDX_W+1)'(NUM_PORTS))
                w_sum = w_sum - (IDX_W+1)'(NUM_PORTS);
            w_cand = w_sum[IDX_W-1:0];
            if (!w_found && mreq[w_cand]) begin
                w_found        = 1'b1;
                winner[w_cand] = 1'b1;
                winner_idx     = w_cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/noc_output_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : noc_output_port_arbiter
// Description : Wormhole round-robin arbiter for one router output port; the
//               grant is held until the packet tail transfers downstream.
//               Optional lock watchdog enabled by NOC_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module noc_output_port_arbiter #(
    parameter int         NUM_PORTS      = 5,
    parameter int         OUT_PORT_ID    = 0,
    parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_PORTS-1:0]      req,
    input  logic                      xfer,
    input  logic                      xfer_tail,
    output logic [NUM_PORTS-1:0]      grant,
    output logic                      grant_valid,
    output logic [noc_pkg::IDX_W-1:0] grant_idx,
    output logic                      protocol_err
`ifdef NOC_ARB_TIMEOUT_EN
    ,
    output logic                      arb_timeout
`endif
);
    import noc_pkg::*;

    // LOCAL may legitimately loop back; every other port must not U-turn.
    localparam logic [NUM_PORTS-1:0] c_uturn_mask =
        (OUT_PORT_ID == PORT_LOCAL) ? '0 : (NUM_PORTS'(1) << OUT_PORT_ID);

    logic [0:0]           r_state;
    logic [IDX_W-1:0]     r_rr_ptr;
    logic [NUM_PORTS-1:0] w_mreq;
    logic [NUM_PORTS-1:0] w_winner;
    logic [IDX_W-1:0]     w_winner_idx;

    assign w_mreq = req & ~c_uturn_mask;

    rr_priority_picker #(
        .NUM_PORTS (NUM_PORTS)
    ) u_picker (
        .mreq       (w_mreq),
        .rr_ptr     (r_rr_ptr),
        .winner     (w_winner),
        .winner_idx (w_winner_idx)
    );

`ifdef NOC_ARB_TIMEOUT_EN
    logic [7:0] r_wdog;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ARB_IDLE;
            r_rr_ptr     <= '0;
            r_wdog       <= '0;
            grant        <= '0;
            grant_valid  <= 1'b0;
            grant_idx    <= '0;
            protocol_err <= 1'b0;
            arb_timeout  <= 1'b0;
        end else begin
            arb_timeout <= 1'b0;
            case (r_state)
                ARB_IDLE: begin
                    r_wdog <= '0;
                    if (xfer)
                        protocol_err <= 1'b1;
                    if (w_mreq != '0) begin
                        r_state     <= ARB_LOCKED;
                        grant       <= w_winner;
                        grant_valid <= 1'b1;
                        grant_idx   <= w_winner_idx;
                    end
                end
                default: begin
                    if (xfer && xfer_tail) begin
                        r_state     <= ARB_IDLE;
                        r_rr_ptr    <= rr_next(grant_idx, NUM_PORTS);
                        r_wdog      <= '0;
                        grant       <= '0;
                        grant_valid <= 1'b0;
                        grant_idx   <= '0;
                    end else if (xfer) begin
                        r_wdog <= '0;
                    end else if (r_wdog + 8'd1 >= TIMEOUT_CYCLES) begin
                        // Stalled lock: release it as if the tail had gone.
                        r_state     <= ARB_IDLE;
                        r_rr_ptr    <= rr_next(grant_idx, NUM_PORTS);
                        r_wdog      <= '0;
                        grant       <= '0;
                        grant_valid <= 1'b0;
                        grant_idx   <= '0;
                        arb_timeout <= 1'b1;
                    end else begin
                        r_wdog <= r_wdog + 8'd1;
                    end
                end
            endcase
        end
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT_CYCLES;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ARB_IDLE;
            r_rr_ptr     <= '0;
            grant        <= '0;
            grant_valid  <= 1'b0;
            grant_idx    <= '0;
            protocol_err <= 1'b0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (xfer)
                        protocol_err <= 1'b1;
                    if (w_mreq != '0) begin
                        r_state     <= ARB_LOCKED;
                        grant       <= w_winner;
                        grant_valid <= 1'b1;
                        grant_idx   <= w_winner_idx;
                    end
                end
                default: begin
                    if (xfer && xfer_tail) begin
                        r_state     <= ARB_IDLE;
                        r_rr_ptr    <= rr_next(grant_idx, NUM_PORTS);
                        grant       <= '0;
                        grant_valid <= 1'b0;
                        grant_idx   <= '0;
                    end
                end
            endcase
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_noc_output_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_noc_output_port_arbiter
// Description : Self-checking bench; two arbiters (LOCAL and NORTH outputs)
//               share stimulus and are compared against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_output_port_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] req;
    logic       xfer;
    logic       xfer_tail;

    logic [4:0] grant [2];
    logic       gv    [2];
    logic [2:0] gidx  [2];
    logic       perr  [2];
`ifdef NOC_ARB_TIMEOUT_EN
    logic       arb_to [2];
`endif

    int  total = 0;
    int  bad   = 0;
    bit  chk_on = 1'b0;

    int  m_id   [2] = '{0, 2};
    bit  m_lock [2];
    int  m_gidx [2];
    int  m_ptr  [2];
    bit  m_perr [2];

    int  e0 [6] = '{0, 1, 2, 3, 4, 0};
    int  e1 [6] = '{0, 1, 3, 4, 0, 1};

    always #5 clk = ~clk;

    noc_output_port_arbiter #(
        .NUM_PORTS      (5),
        .OUT_PORT_ID    (0),
        .TIMEOUT_CYCLES (8'd255)
    ) u_dut0 (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .xfer         (xfer),
        .xfer_tail    (xfer_tail),
        .grant        (grant[0]),
        .grant_valid  (gv[0]),
        .grant_idx    (gidx[0]),
        .protocol_err (perr[0])
`ifdef NOC_ARB_TIMEOUT_EN
        ,
        .arb_timeout  (arb_to[0])
`endif
    );

    noc_output_port_arbiter #(
        .NUM_PORTS      (5),
        .OUT_PORT_ID    (2),
        .TIMEOUT_CYCLES (8'd255)
    ) u_dut1 (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .xfer         (xfer),
        .xfer_tail    (xfer_tail),
        .grant        (grant[1]),
        .grant_valid  (gv[1]),
        .grant_idx    (gidx[1]),
        .protocol_err (perr[1])
`ifdef NOC_ARB_TIMEOUT_EN
        ,
        .arb_timeout  (arb_to[1])
`endif
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_grant(input int i);
        return m_lock[i] ? (1 << m_gidx[i]) : 0;
    endfunction

    // Abstract model: locked/idle flag, granted port, next-priority port.
    task automatic model_step();
        int  mreq;
        bit  found;
        int  p;
        for (int i = 0; i < 2; i++) begin
            mreq = int'(req);
            if (m_id[i] != 0)
                mreq = mreq & ~(1 << m_id[i]);
            if (rst) begin
                m_lock[i] = 1'b0;
                m_gidx[i] = 0;
                m_ptr[i]  = 0;
                m_perr[i] = 1'b0;
            end else if (!m_lock[i]) begin
                if (xfer)
                    m_perr[i] = 1'b1;
                found = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    p = (m_ptr[i] + k) % 5;
                    if (!found && ((mreq >> p) & 1) != 0) begin
                        found     = 1'b1;
                        m_lock[i] = 1'b1;
                        m_gidx[i] = p;
                    end
                end
            end else if (xfer && xfer_tail) begin
                m_lock[i] = 1'b0;
                m_ptr[i]  = (m_gidx[i] + 1) % 5;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("grant[%0d]", i), int'(grant[i]), exp_grant(i));
                check($sformatf("grant_valid[%0d]", i), int'(gv[i]), int'(m_lock[i]));
                check($sformatf("grant_idx[%0d]", i), int'(gidx[i]), m_lock[i] ? m_gidx[i] : 0);
                check($sformatf("protocol_err[%0d]", i), int'(perr[i]), int'(m_perr[i]));
            end
        end
    end

    initial begin
        rst = 1'b1; req = '0; xfer = 1'b0; xfer_tail = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_lock[i] = 1'b0; m_gidx[i] = 0; m_ptr[i] = 0; m_perr[i] = 1'b0;
        end
        cyc();
        chk_on = 1'b1;
        cyc();
        rst = 1'b0;
        check("reset_grant", int'(grant[0]), 0);
        check("reset_valid", int'(gv[0]), 0);
        check("reset_idx", int'(gidx[1]), 0);
        check("reset_perr", int'(perr[1]), 0);

        // U-turn masking on the NORTH output; LOCAL output is not masked.
        req = 5'b00100;
        cyc();
        check("local_no_mask_grant", int'(grant[0]), 5'b00100);
        check("local_no_mask_idx", int'(gidx[0]), 2);
        repeat (9) cyc();
        check("uturn_masked", int'(grant[1]), 0);
        req = 5'b00110;
        cyc();
        check("uturn_other_grant", int'(grant[1]), 5'b00010);
        check("uturn_other_idx", int'(gidx[1]), 1);

        // Grant held while the owner drops its request and others stall.
        req = 5'b00010;
        repeat (20) cyc();
        check("hold_port2", int'(grant[0]), 5'b00100);

        xfer = 1'b1; xfer_tail = 1'b1; req = 5'b10010;
        cyc();
        xfer = 1'b0; xfer_tail = 1'b0;
        check("tail_release", int'(grant[0]), 0);
        check("tail_release_valid", int'(gv[1]), 0);
        cyc();
        check("after_bubble_grant4", int'(grant[0]), 5'b10000);
        req = 5'b00010;
        repeat (20) cyc();
        check("hold_port4", int'(grant[0]), 5'b10000);
        xfer = 1'b1; xfer_tail = 1'b1;
        cyc();
        xfer = 1'b0; xfer_tail = 1'b0;
        check("bubble_after_port4", int'(grant[0]), 0);
        cyc();
        check("wrap_to_port1", int'(grant[0]), 5'b00010);

        // Stray transfer while idle sets the sticky error.
        req = '0; xfer = 1'b1; xfer_tail = 1'b1;
        cyc();
        xfer_tail = 1'b0;
        cyc();
        xfer = 1'b0;
        cyc();
        check("perr_set0", int'(perr[0]), 1);
        check("perr_set1", int'(perr[1]), 1);
        repeat (3) cyc();
        check("perr_sticky", int'(perr[0]), 1);

        // Reset while locked.
        req = 5'b11111;
        cyc();
        check("locked_before_rst", int'(gv[0]), 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("rst_lock_grant", int'(grant[0]), 0);
        check("rst_lock_idx", int'(gidx[0]), 0);
        check("rst_lock_perr", int'(perr[0]), 0);

        // Round-robin with single-flit packets, one idle cycle between grants.
        for (int n = 0; n < 6; n++) begin
            cyc();
            check($sformatf("rr_order0_%0d", n), int'(gidx[0]), e0[n]);
            check($sformatf("rr_order1_%0d", n), int'(gidx[1]), e1[n]);
            xfer = 1'b1; xfer_tail = 1'b1;
            cyc();
            xfer = 1'b0; xfer_tail = 1'b0;
            check($sformatf("rr_bubble_%0d", n), int'(gv[0]), 0);
        end

        // Randomised traffic, checked every cycle by the compare process.
        for (int n = 0; n < 3000; n++) begin
            req       = 5'($urandom_range(0, 31));
            xfer      = ($urandom_range(0, 2) == 0);
            xfer_tail = ($urandom_range(0, 1) == 0);
            rst       = ($urandom_range(0, 299) == 0);
            cyc();
        end
        rst = 1'b0; xfer = 1'b0; req = '0;
        cyc();
        @(posedge clk);
        chk_on = 1'b0;
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
